// File: rtl/coin_bank_if.sv
// Handshake/bus bundle between the coin manager and the surrounding game logic.
// life_up exists only when COIN_LIFE_EN is defined.
interface coin_bank_if #(
   parameter int NUM_COINS = 4,
   parameter int CNT_W     = 8
);
   logic                 frame_clk;
   logic                 start;
   logic [1:0]           start_block;
   logic                 Shift;
   logic [9:0]           DrawX;
   logic [9:0]           DrawY;
   logic [9:0]           Mario_X_Pos;
   logic [9:0]           Mario_Y_Pos;
   logic                 is_coin;
   logic [2:0]           coin_idx;
   logic                 coin_taken;
   logic [NUM_COINS-1:0] taken_mask;
   logic                 spawn_dropped;
   logic [CNT_W-1:0]     coin_count;
   logic [NUM_COINS-1:0] active_mask;
`ifdef COIN_LIFE_EN
   logic                 life_up;

   modport master (
      output frame_clk, start, start_block, Shift, DrawX, DrawY, Mario_X_Pos, Mario_Y_Pos,
      input  is_coin, coin_idx, coin_taken, taken_mask, spawn_dropped, coin_count, active_mask,
             life_up
   );
   modport slave (
      input  frame_clk, start, start_block, Shift, DrawX, DrawY, Mario_X_Pos, Mario_Y_Pos,
      output is_coin, coin_idx, coin_taken, taken_mask, spawn_dropped, coin_count, active_mask,
             life_up
   );
`else
   modport master (
      output frame_clk, start, start_block, Shift, DrawX, DrawY, Mario_X_Pos, Mario_Y_Pos,
      input  is_coin, coin_idx, coin_taken, taken_mask, spawn_dropped, coin_count, active_mask
   );
   modport slave (
      input  frame_clk, start, start_block, Shift, DrawX, DrawY, Mario_X_Pos, Mario_Y_Pos,
      output is_coin, coin_idx, coin_taken, taken_mask, spawn_dropped, coin_count, active_mask
   );
`endif
endinterface

// File: rtl/coin_bank.sv
// Multi-slot coin manager: spawn, scroll, retire, collect and draw up to NUM_COINS coins.
// Optional macro COIN_LIFE_EN adds a mod-100 collection counter with a life_up pulse.
module coin_bank #(
   parameter int NUM_COINS  = 4,
   parameter int COIN_R     = 19,
   parameter int SPAWN_X    = 500,
   parameter int X_MIN      = 120,
   parameter int SHIFT_STEP = 40,
   parameter int CNT_W      = 8
) (
   input  logic      Clk,
   input  logic      Reset,
   coin_bank_if.slave bus
);
   localparam logic [9:0]  SPAWN_X_L = 10'(SPAWN_X);
   localparam logic [9:0]  X_MIN_L   = 10'(X_MIN);
   localparam logic [9:0]  STEP_L    = 10'(SHIFT_STEP);
   localparam logic [22:0] R2        = 23'(COIN_R * COIN_R);

   function automatic logic [22:0] dist_sq(input logic [9:0] ax, input logic [9:0] ay,
                                           input logic [9:0] bx, input logic [9:0] by);
      logic signed [10:0] dx, dy;
      logic [10:0]        adx, ady;
      logic [21:0]        sx, sy;
      dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
      adx = dx[10] ? (~dx + 11'sd1) : dx;
      ady = dy[10] ? (~dy + 11'sd1) : dy;
      sx  = 22'(adx) * 22'(adx);
      sy  = 22'(ady) * 22'(ady);
      return {1'b0, sx} + {1'b0, sy};
   endfunction

   function automatic logic [3:0] popcnt(input logic [NUM_COINS-1:0] v);
      logic [3:0] s;
      s = '0;
      for (int k = 0; k < NUM_COINS; k++) s = s + 4'(v[k]);
      return s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
      logic [CNT_W:0] s;
      s = (CNT_W+1)'(a) + (CNT_W+1)'(b);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   function automatic logic [9:0] row_y(input logic [1:0] blk);
      return 10'd140 + 10'(blk) * 10'd40;
   endfunction

   logic [NUM_COINS-1:0] active;
   logic [9:0]           x [NUM_COINS];
   logic [9:0]           y [NUM_COINS];
   logic                 frame_p0, frame_p1, fe_p2;
   logic [NUM_COINS-1:0] taken_mask_q;
   logic                 coin_taken_q, dropped_q;
   logic [CNT_W-1:0]     count_q;

   logic [NUM_COINS-1:0] hit;
   logic                 any_free;
   logic [2:0]           tgt;
   logic                 is_coin_c;
   logic [2:0]           idx_c;

   // Collision against Mario, spawn target selection, and per-pixel draw test
   always_comb begin
      hit      = '0;
      any_free = 1'b0;
      tgt      = '0;
      is_coin_c = 1'b0;
      idx_c     = '0;
      for (int i = NUM_COINS - 1; i >= 0; i--) begin
         hit[i] = active[i] && (dist_sq(bus.Mario_X_Pos, bus.Mario_Y_Pos, x[i], y[i]) <= R2);
         if (!active[i]) begin
            any_free = 1'b1;
            tgt      = 3'(i);
         end
         if (active[i] && (dist_sq(bus.DrawX, bus.DrawY, x[i], y[i]) <= R2)) begin
            is_coin_c = 1'b1;
            idx_c     = 3'(i);
         end
      end
   end

   // Frame edge sync and slot state update
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         active       <= '0;
         frame_p0     <= 1'b0;
         frame_p1     <= 1'b0;
         fe_p2        <= 1'b0;
         taken_mask_q <= '0;
         coin_taken_q <= 1'b0;
         dropped_q    <= 1'b0;
         count_q      <= '0;
         for (int i = 0; i < NUM_COINS; i++) begin
            x[i] <= '0;
            y[i] <= '0;
         end
      end else begin
         frame_p0     <= bus.frame_clk;
         frame_p1     <= frame_p0;
         fe_p2        <= frame_p0 & ~frame_p1;
         taken_mask_q <= hit;
         coin_taken_q <= |hit;
         dropped_q    <= bus.start & ~any_free;
         count_q      <= sat_add(count_q, popcnt(hit));
         for (int i = 0; i < NUM_COINS; i++) begin
            if (hit[i]) begin
               active[i] <= 1'b0;
            end else if (active[i] && fe_p2) begin
               if (x[i] < X_MIN_L)  active[i] <= 1'b0;
               else if (bus.Shift)  x[i] <= x[i] - STEP_L;
            end else if (bus.start && !active[i] && (tgt == 3'(i))) begin
               active[i] <= 1'b1;
               x[i]      <= SPAWN_X_L;
               y[i]      <= row_y(bus.start_block);
            end
         end
      end
   end

   assign bus.is_coin       = is_coin_c;
   assign bus.coin_idx      = idx_c;
   assign bus.coin_taken    = coin_taken_q;
   assign bus.taken_mask    = taken_mask_q;
   assign bus.spawn_dropped = dropped_q;
   assign bus.coin_count    = count_q;
   assign bus.active_mask   = active;

`ifdef COIN_LIFE_EN
   logic [6:0] life_cnt;
   logic       life_up_q;
   logic [7:0] life_sum;

   assign life_sum = {1'b0, life_cnt} + 8'(popcnt(hit));

   // Wraps at 100 with a pulse aligned to coin_taken
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         life_cnt  <= '0;
         life_up_q <= 1'b0;
      end else if (life_sum >= 8'd100) begin
         life_cnt  <= 7'(life_sum - 8'd100);
         life_up_q <= 1'b1;
      end else begin
         life_cnt  <= life_sum[6:0];
         life_up_q <= 1'b0;
      end
   end

   assign bus.life_up = life_up_q;
`endif
endmodule

// File: tb/tb_coin_bank.sv
// Directed self-checking bench for coin_bank (build with COIN_LIFE_EN to cover life_up).
`timescale 1ns/1ps
module tb_coin_bank;
   logic Clk = 1'b0;
   logic Reset;
   int   n_chk = 0;
   int   n_fail = 0;
   logic life_seen = 1'b0;

   coin_bank_if #(.NUM_COINS(4), .CNT_W(8)) bus ();

   coin_bank #(.NUM_COINS(4), .COIN_R(19), .SPAWN_X(500), .X_MIN(120),
               .SHIFT_STEP(40), .CNT_W(8)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
`ifdef COIN_LIFE_EN
      life_seen = life_seen | bus.life_up;
`endif
   endtask

   task automatic mario(input int mx, input int my);
      bus.Mario_X_Pos = 10'(mx);
      bus.Mario_Y_Pos = 10'(my);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      tick();
   endtask

   task automatic spawn(input int blk);
      bus.start = 1'b1;
      bus.start_block = 2'(blk);
      tick();
      bus.start = 1'b0;
   endtask

   task automatic frame_edge();
      bus.frame_clk = 1'b1;
      repeat (4) tick();
      bus.frame_clk = 1'b0;
      repeat (4) tick();
   endtask

   // Spawns n coins on row 0 and collects them all in one cycle; outputs of the hit are visible on return.
   task automatic hit_round(input int n);
      mario(0, 0);
      for (int k = 0; k < n; k++) spawn(0);
      mario(500, 140);
      tick();
      mario(0, 0);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus.start = 1'b1;
      bus.start_block = 2'd1;
      tick();
      tick();
      n_chk++; if (bus.active_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_active: got %b expected 0000", bus.active_mask); end
      n_chk++; if (bus.coin_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.coin_count); end
      n_chk++; if (bus.coin_taken !== 1'b0 || bus.taken_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_taken: got %b/%b expected 0/0000", bus.coin_taken, bus.taken_mask); end
      n_chk++; if (bus.spawn_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped: got %b expected 0", bus.spawn_dropped); end
      n_chk++; if (bus.is_coin !== 1'b0 || bus.coin_idx !== 3'd0) begin n_fail++; $display("FAIL reset_draw: got %b/%0d expected 0/0", bus.is_coin, bus.coin_idx); end
      bus.start = 1'b0;
      Reset = 1'b0;
      tick();
      n_chk++; if (bus.active_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_start_ignored: got %b expected 0000", bus.active_mask); end
   endtask

   task automatic test_spawn();
      spawn(2);
      n_chk++; if (bus.active_mask !== 4'b0001) begin n_fail++; $display("FAIL spawn_active: got %b expected 0001", bus.active_mask); end
      n_chk++; if (dut.x[0] !== 10'd500 || dut.y[0] !== 10'd220) begin n_fail++; $display("FAIL spawn_pos: got %0d,%0d expected 500,220", dut.x[0], dut.y[0]); end
      bus.DrawX = 10'd500; bus.DrawY = 10'd220; #1;
      n_chk++; if (bus.is_coin !== 1'b1 || bus.coin_idx !== 3'd0) begin n_fail++; $display("FAIL draw_centre: got %b/%0d expected 1/0", bus.is_coin, bus.coin_idx); end
      bus.DrawX = 10'd520; #1;
      n_chk++; if (bus.is_coin !== 1'b0) begin n_fail++; $display("FAIL draw_outside: got %b expected 0", bus.is_coin); end
      bus.DrawX = 10'd519; #1;
      n_chk++; if (bus.is_coin !== 1'b1) begin n_fail++; $display("FAIL draw_radius: got %b expected 1", bus.is_coin); end
   endtask

   task automatic test_scroll();
      logic seen_taken;
      int   exp_x;
      bus.Shift = 1'b0;
      frame_edge();
      n_chk++; if (dut.x[0] !== 10'd500) begin n_fail++; $display("FAIL scroll_hold: got %0d expected 500", dut.x[0]); end
      bus.Shift = 1'b1;
      seen_taken = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         frame_edge();
         seen_taken = seen_taken | bus.coin_taken;
         exp_x = 500 - 40 * k;
         n_chk++; if (dut.x[0] !== 10'(exp_x)) begin n_fail++; $display("FAIL scroll_step%0d: got %0d expected %0d", k, dut.x[0], exp_x); end
      end
      n_chk++; if (bus.active_mask !== 4'b0001) begin n_fail++; $display("FAIL scroll_alive_at_100: got %b expected 0001", bus.active_mask); end
      frame_edge();
      seen_taken = seen_taken | bus.coin_taken;
      bus.Shift = 1'b0;
      n_chk++; if (bus.active_mask !== 4'b0000) begin n_fail++; $display("FAIL scroll_retire: got %b expected 0000", bus.active_mask); end
      n_chk++; if (bus.coin_count !== 8'd0 || seen_taken !== 1'b0) begin n_fail++; $display("FAIL retire_not_counted: got count %0d taken %b expected 0/0", bus.coin_count, seen_taken); end
   endtask

   task automatic test_drop();
      for (int b = 0; b < 4; b++) spawn(b);
      n_chk++; if (bus.active_mask !== 4'b1111) begin n_fail++; $display("FAIL drop_fill: got %b expected 1111", bus.active_mask); end
      n_chk++; if (dut.y[0] !== 10'd140 || dut.y[3] !== 10'd260) begin n_fail++; $display("FAIL drop_rows: got %0d,%0d expected 140,260", dut.y[0], dut.y[3]); end
      n_chk++; if (bus.spawn_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_early: got %b expected 0", bus.spawn_dropped); end
      spawn(1);
      n_chk++; if (bus.spawn_dropped !== 1'b1 || bus.active_mask !== 4'b1111) begin n_fail++; $display("FAIL drop_pulse: got %b/%b expected 1/1111", bus.spawn_dropped, bus.active_mask); end
      n_chk++; if (dut.y[1] !== 10'd180 || dut.x[1] !== 10'd500) begin n_fail++; $display("FAIL drop_unchanged: got %0d,%0d expected 500,180", dut.x[1], dut.y[1]); end
      tick();
      n_chk++; if (bus.spawn_dropped !== 1'b0) begin n_fail++; $display("FAIL drop_once: got %b expected 0", bus.spawn_dropped); end
      bus.DrawX = 10'd500; bus.DrawY = 10'd260; #1;
      n_chk++; if (bus.is_coin !== 1'b1 || bus.coin_idx !== 3'd3) begin n_fail++; $display("FAIL draw_idx3: got %b/%0d expected 1/3", bus.is_coin, bus.coin_idx); end
      bus.DrawY = 10'd150; #1;
      n_chk++; if (bus.coin_idx !== 3'd0) begin n_fail++; $display("FAIL draw_lowest: got %0d expected 0", bus.coin_idx); end
   endtask

   task automatic test_collect();
      do_reset();
      spawn(2);
      mario(520, 220);
      tick(); tick();
      n_chk++; if (bus.coin_taken !== 1'b0 || bus.active_mask !== 4'b0001) begin n_fail++; $display("FAIL nohit_400: got %b/%b expected 0/0001", bus.coin_taken, bus.active_mask); end
      mario(505, 230);
      tick();
      n_chk++; if (bus.coin_taken !== 1'b1 || bus.taken_mask !== 4'b0001) begin n_fail++; $display("FAIL hit_pulse: got %b/%b expected 1/0001", bus.coin_taken, bus.taken_mask); end
      n_chk++; if (bus.coin_count !== 8'd1 || bus.active_mask !== 4'b0000) begin n_fail++; $display("FAIL hit_state: got %0d/%b expected 1/0000", bus.coin_count, bus.active_mask); end
      tick();
      n_chk++; if (bus.coin_taken !== 1'b0 || bus.coin_count !== 8'd1) begin n_fail++; $display("FAIL hit_no_retrigger: got %b/%0d expected 0/1", bus.coin_taken, bus.coin_count); end
      mario(0, 0);
      spawn(2);
      mario(519, 220);
      bus.start = 1'b1;
      bus.start_block = 2'd0;
      tick();
      bus.start = 1'b0;
      mario(0, 0);
      n_chk++; if (bus.active_mask !== 4'b0010 || bus.taken_mask !== 4'b0001) begin n_fail++; $display("FAIL hit_spawn_same_cycle: got %b/%b expected 0010/0001", bus.active_mask, bus.taken_mask); end
      n_chk++; if (bus.coin_count !== 8'd2 || dut.y[1] !== 10'd140) begin n_fail++; $display("FAIL hit_radius_count: got %0d/%0d expected 2/140", bus.coin_count, dut.y[1]); end
   endtask

   task automatic test_multi_hit();
      do_reset();
      spawn(1);
      spawn(1);
      mario(500, 180);
      tick();
      mario(0, 0);
      n_chk++; if (bus.taken_mask !== 4'b0011 || bus.coin_taken !== 1'b1) begin n_fail++; $display("FAIL multi_mask: got %b/%b expected 0011/1", bus.taken_mask, bus.coin_taken); end
      n_chk++; if (bus.coin_count !== 8'd2 || bus.active_mask !== 4'b0000) begin n_fail++; $display("FAIL multi_count: got %0d/%b expected 2/0000", bus.coin_count, bus.active_mask); end
      tick();
      n_chk++; if (bus.coin_taken !== 1'b0 || bus.taken_mask !== 4'b0000) begin n_fail++; $display("FAIL multi_single: got %b/%b expected 0/0000", bus.coin_taken, bus.taken_mask); end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 3; k++) spawn(0);
      bus.Shift = 1'b1;
      bus.frame_clk = 1'b1;
      tick(); tick(); tick();
      bus.DrawX = 10'd460; bus.DrawY = 10'd140; #1;
      n_chk++; if (bus.active_mask !== 4'b0111 || bus.is_coin !== 1'b1 || bus.coin_count !== 8'd2) begin n_fail++; $display("FAIL async_pre: got %b/%b/%0d expected 0111/1/2", bus.active_mask, bus.is_coin, bus.coin_count); end
      #1;
      Reset = 1'b1;
      #1;
      n_chk++; if (bus.active_mask !== 4'b0000 || bus.is_coin !== 1'b0 || bus.coin_count !== 8'd0) begin n_fail++; $display("FAIL async_reset: got %b/%b/%0d expected 0000/0/0", bus.active_mask, bus.is_coin, bus.coin_count); end
      bus.frame_clk = 1'b0;
      bus.Shift = 1'b0;
      tick();
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_saturate();
      do_reset();
      for (int r = 0; r < 63; r++) hit_round(4);
      n_chk++; if (bus.coin_count !== 8'd252) begin n_fail++; $display("FAIL sat_252: got %0d expected 252", bus.coin_count); end
      hit_round(4);
      n_chk++; if (bus.coin_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", bus.coin_count); end
      hit_round(1);
      n_chk++; if (bus.coin_count !== 8'd255 || bus.coin_taken !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got %0d/%b expected 255/1", bus.coin_count, bus.coin_taken); end
   endtask

`ifdef COIN_LIFE_EN
   task automatic test_life();
      do_reset();
      life_seen = 1'b0;
      for (int r = 0; r < 24; r++) hit_round(4);
      hit_round(3);
      n_chk++; if (dut.life_cnt !== 7'd99 || life_seen !== 1'b0) begin n_fail++; $display("FAIL life_99: got %0d/%b expected 99/0", dut.life_cnt, life_seen); end
      hit_round(1);
      n_chk++; if (bus.life_up !== 1'b1 || bus.coin_taken !== 1'b1) begin n_fail++; $display("FAIL life_pulse: got %b/%b expected 1/1", bus.life_up, bus.coin_taken); end
      n_chk++; if (dut.life_cnt !== 7'd0 || bus.coin_count !== 8'd100) begin n_fail++; $display("FAIL life_wrap: got %0d/%0d expected 0/100", dut.life_cnt, bus.coin_count); end
      tick();
      n_chk++; if (bus.life_up !== 1'b0) begin n_fail++; $display("FAIL life_once: got %b expected 0", bus.life_up); end
   endtask
`endif

   initial begin
      Reset = 1'b1;
      bus.frame_clk = 1'b0;
      bus.start = 1'b0;
      bus.start_block = 2'd0;
      bus.Shift = 1'b0;
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd0;
      mario(0, 0);
      test_reset();
      test_spawn();
      test_scroll();
      test_drop();
      test_collect();
      test_multi_hit();
      test_async_reset();
      test_saturate();
`ifdef COIN_LIFE_EN
      test_life();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/coin_bank.md
Name: coin_bank

Overview:
- Multi-slot coin manager; generalises the single-coin object to NUM_COINS independent coins.
- Each coin:
  - spawns at a fixed X on a block row;
  - scrolls left with the level on frame edges while Shift is high;
  - retires when it passes the left margin or when Mario touches it.
- Sits beside the Mario and block logic.
- Feeds is_coin to the colour mapper and coin events to the score/HUD logic.

Parameters:
- NUM_COINS, 4, number of coin slots (1-8).
- COIN_R, 19, coin radius in pixels; collision and draw test is dist² <= COIN_R².
- SPAWN_X, 500, X centre given to a newly spawned coin.
- X_MIN, 120, left margin; a coin with X < X_MIN retires on the next frame edge. Must be >= SHIFT_STEP.
- SHIFT_STEP, 40, pixels moved left per frame edge while Shift=1.
- CNT_W, 8, width of coin_count.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  vertical-sync-rate clock, sampled in the Clk domain.
- start  in  1  spawn request, one Clk cycle.
- start_block  in  2  block row for the spawn.
- Shift  in  1  level scroll enable.
- DrawX, DrawY  in  10 each  current pixel.
- Mario_X_Pos, Mario_Y_Pos  in  10 each  Mario centre.
- is_coin  out  1  current pixel lies inside any active coin.
- coin_idx  out  3  lowest active slot covering the pixel; 0 when is_coin=0.
- coin_taken  out  1  one-cycle pulse, at least one coin collected this cycle.
- taken_mask  out  NUM_COINS  slots collected this cycle; registered, one cycle wide.
- spawn_dropped  out  1  one-cycle pulse, spawn refused because no slot was free.
- coin_count  out  CNT_W  total coins collected; saturates at all-ones.
- active_mask  out  NUM_COINS  occupied slots.

Behaviour:
- Reset (async, active-high): all slots inactive with X=Y=0; coin_taken, taken_mask, spawn_dropped, coin_count = 0; frame-edge detector cleared. is_coin=0 follows from no active slots.
- Frame edge:
  - frame_clk passes through a two-flop delay; fe = registered (frame_clk & ~frame_clk_d).
  - fe is high for exactly one Clk cycle per rising edge of frame_clk.
- Per-slot collision:
  - dx = Mario_X_Pos - X, dy = Mario_Y_Pos - Y, both signed 11-bit.
  - hit[i] = active[i] & (dx²+dy² <= COIN_R²).
  - Squares are computed unsigned, 22-bit; the sum is 23-bit.
- Slot update priority each cycle, highest first:
  1. hit[i]: clear active[i]; set taken_mask[i]=1 on the next cycle.
  2. fe with X[i] < X_MIN: clear active[i]. Not counted as a collection.
  3. fe with Shift=1: X[i] -= SHIFT_STEP.
  4. Otherwise hold.
- Spawn:
  - On start, the target is the lowest-index slot with active=0, using registered state at the start of the cycle.
  - A slot freed in the same cycle is not reused until the next cycle.
  - Target slot loads X=SPAWN_X, Y=40*start_block+140 (row 0 gives 140, row 3 gives 260), active=1.
  - A freshly spawned coin is not shifted or hit-tested in its spawn cycle.
  - If no slot is free, nothing changes and spawn_dropped pulses on the next cycle.
- Outputs:
  - coin_taken = |taken_mask; both are registered, so latency is 1 cycle after the hit.
  - coin_count += popcount(hit), saturating. Several simultaneous hits all count.
  - is_coin and coin_idx are combinational from DrawX/DrawY and registered slot state, using the same distance test with DrawX/DrawY in place of Mario's position.
- A collected coin never re-triggers: it is inactive from the cycle after the hit.
- A start pulse during Reset is ignored.

Optional Feature:
- Macro: COIN_LIFE_EN.
- Defined:
  - adds output life_up (1 bit);
  - adds a 7-bit counter that advances by popcount(hit) per cycle;
  - on reaching or passing 100, it wraps by subtracting 100 and life_up pulses for one cycle, aligned with coin_taken;
  - the counter is cleared by Reset.
- Not defined: no life_up port, no counter; coin_count is the only tally.

Test Plan:
- Reset, then start=1, start_block=2 -> slot0 active, X=500, Y=220; active_mask=0001; DrawX=500, DrawY=220 gives is_coin=1, coin_idx=0.
- Slot0 at X=500 with Shift=1 and 10 frame edges -> X steps 460, 420 … 140, 100. At the edge after reaching 100, slot0 retires: active_mask=0000, coin_count unchanged, no coin_taken.
- Four spawns, then a fifth with NUM_COINS=4 -> spawn_dropped pulses once; slots unchanged.
- Mario at (505,230) vs coin at (500,220) (dist² 125 <= 361) -> coin_taken and taken_mask=0001 one cycle later, coin_count=1, slot0 free. Mario at (520,220) (dist² 400) -> no hit.
- Two coins at the same position, both hit in one cycle -> taken_mask=0011, coin_count += 2, single-cycle coin_taken.
- Assert Reset asynchronously mid-scroll with 3 coins active -> all outputs 0 immediately, without waiting for a Clk edge.
- With COIN_LIFE_EN, preload 99 collections, then 1 more -> life_up pulses once and the internal count reads 0.
